// File: rtl/pe_array_wavefront_ctrl.sv
// pe_array_wavefront_ctrl
//   Per-PE enable/stall generator for a ROWS x COLS systolic PE array. A tile runs
//   IDLE -> PREHEAT -> COMPUTE -> DONE. PE (r,c) is enabled while the diagonal wave
//   counter w lies in [r+c, r+c+tile_len). The whole array is back-pressured when an
//   active row's ifmap FIFO is empty or an active column's opsum FIFO is full.
//   Depthwise mode (layer type 1) activates only the diagonal PEs.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start_i, abort_i    start a tile (IDLE only) / return to IDLE from any state
//   layer_type_i        0 pointwise, 1 depthwise, 2 standard, 3 illegal
//   preheat_len_i       preheat cycles, counted on non-stalled cycles only
//   tile_len_i          tokens streamed per PE
//   ifmap_fifo_empty_i  per-row ifmap FIFO empty
//   opsum_fifo_full_i   per-column opsum FIFO full
//   pe_en_o, pe_stall_o per-PE enable / hold, bit r*COLS+c
//   busy_o, done_o      PREHEAT/COMPUTE, 1-cycle tile completion pulse
//   err_o               1-cycle pulse after a start with layer type 3
//
// state     | meaning
// S_IDLE    | waiting for start_i
// S_PREHEAT | filling the pipeline, PEs disabled
// S_COMPUTE | diagonal wavefront running
// S_DONE    | one-cycle completion pulse
module pe_array_wavefront_ctrl #(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [1:0]           layer_type_i,
  input  logic [CNT_W-1:0]     preheat_len_i,
  input  logic [CNT_W-1:0]     tile_len_i,
  input  logic [ROWS-1:0]      ifmap_fifo_empty_i,
  input  logic [COLS-1:0]      opsum_fifo_full_i,
  output logic [ROWS*COLS-1:0] pe_en_o,
  output logic [ROWS*COLS-1:0] pe_stall_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int MIN_RC = (ROWS < COLS) ? ROWS : COLS;
  localparam int W      = CNT_W + 1;
  localparam logic [W-1:0] LAST_FULL = W'(ROWS + COLS - 2);
  localparam logic [W-1:0] LAST_DW   = W'(2 * (MIN_RC - 1));

  typedef enum logic [1:0] {S_IDLE, S_PREHEAT, S_COMPUTE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             dw_q, dw_d;
  logic [CNT_W-1:0] pre_len_q, pre_len_d;
  logic [CNT_W-1:0] tile_len_q, tile_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     w_q, w_d;
  logic             err_q, err_d;

  logic [ROWS-1:0] row_act, row_stall;
  logic [COLS-1:0] col_act, col_stall;
  logic            pre_stall, stall_g;
  logic [W-1:0]    tile_ext, w_end;

  // Rows/columns beyond the diagonal are inactive in depthwise mode, so their
  // FIFO flags must not back-pressure the array.
  always_comb begin
    for (int r = 0; r < ROWS; r++) row_act[r] = !dw_q || (r < MIN_RC);
    for (int c = 0; c < COLS; c++) col_act[c] = !dw_q || (c < MIN_RC);
  end

  assign row_stall = ifmap_fifo_empty_i & row_act;
  assign col_stall = opsum_fifo_full_i & col_act;
  assign pre_stall = |row_stall;
  assign stall_g   = (|row_stall) | (|col_stall);
  assign tile_ext  = {1'b0, tile_len_q};
  assign w_end     = tile_ext + (dw_q ? LAST_DW : LAST_FULL);

  always_comb begin
    pe_en_o    = '0;
    pe_stall_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        logic act;
        act = dw_q ? (r == c) : 1'b1;
        if (state_q == S_PREHEAT) begin
          pe_stall_o[r*COLS+c] = act & row_stall[r];
        end else if (state_q == S_COMPUTE) begin
          if (stall_g) pe_stall_o[r*COLS+c] = act;
          else pe_en_o[r*COLS+c] = act && (w_q >= W'(r + c)) && (w_q < W'(r + c) + tile_ext);
        end
      end
    end
  end

  assign busy_o = (state_q == S_PREHEAT) || (state_q == S_COMPUTE);
  assign done_o = (state_q == S_DONE);
  assign err_o  = err_q;

  always_comb begin
    state_d    = state_q;
    dw_d       = dw_q;
    pre_len_d  = pre_len_q;
    tile_len_d = tile_len_q;
    cnt_d      = cnt_q;
    w_d        = w_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (layer_type_i == 2'd3) begin
            err_d = 1'b1;
          end else begin
            dw_d       = (layer_type_i == 2'd1);
            pre_len_d  = preheat_len_i;
            tile_len_d = tile_len_i;
            cnt_d      = '0;
            w_d        = '0;
            if (preheat_len_i != '0)   state_d = S_PREHEAT;
            else if (tile_len_i != '0) state_d = S_COMPUTE;
            else                       state_d = S_DONE;
          end
        end
      end
      S_PREHEAT: begin
        if (!pre_stall) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == pre_len_q)
            state_d = (tile_len_q != '0) ? S_COMPUTE : S_DONE;
        end
      end
      S_COMPUTE: begin
        if (!stall_g) begin
          w_d = w_q + 1'b1;
          if (w_q + 1'b1 == w_end) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
      cnt_d   = '0;
      w_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dw_q       <= 1'b0;
      pre_len_q  <= '0;
      tile_len_q <= '0;
      cnt_q      <= '0;
      w_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dw_q       <= dw_d;
      pre_len_q  <= pre_len_d;
      tile_len_q <= tile_len_d;
      cnt_q      <= cnt_d;
      w_q        <= w_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_pe_array_wavefront_ctrl.sv
// tb_pe_array_wavefront_ctrl
//   Directed bench: a 4x4 instance for the main sequences and an 8x4 instance for
//   the depthwise inactive-row case. Control inputs are shared; each test starts
//   from reset.
module tb_pe_array_wavefront_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_i, abort_i;
  logic [1:0]  layer_type_i;
  logic [15:0] preheat_len_i, tile_len_i;
  logic [3:0]  ifmap_a, opsum_a, opsum_b;
  logic [7:0]  ifmap_b;
  logic [15:0] en_a, stall_a;
  logic [31:0] en_b, stall_b;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_array_wavefront_ctrl #(.ROWS(4), .COLS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .layer_type_i(layer_type_i), .preheat_len_i(preheat_len_i), .tile_len_i(tile_len_i),
    .ifmap_fifo_empty_i(ifmap_a), .opsum_fifo_full_i(opsum_a),
    .pe_en_o(en_a), .pe_stall_o(stall_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

  pe_array_wavefront_ctrl #(.ROWS(8), .COLS(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .layer_type_i(layer_type_i), .preheat_len_i(preheat_len_i), .tile_len_i(tile_len_i),
    .ifmap_fifo_empty_i(ifmap_b), .opsum_fifo_full_i(opsum_b),
    .pe_en_o(en_b), .pe_stall_o(stall_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected 4x4 enable mask straight from the wavefront definition.
  function automatic logic [15:0] exp_en(input int w, input int tile, input bit dw);
    logic [15:0] m;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if ((!dw || r == c) && w >= r + c && w < r + c + tile) m[r*4+c] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; layer_type_i = 2'd0;
    preheat_len_i = '0; tile_len_i = '0;
    ifmap_a = '0; opsum_a = '0; ifmap_b = '0; opsum_b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic start_tile(input logic [1:0] lt, input int pre, input int tile);
    start_i = 1'b1; layer_type_i = lt;
    preheat_len_i = 16'(pre); tile_len_i = 16'(tile);
    tick();
    start_i = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_stall", stall_a, 0);

    // Mode 0, preheat 2, tile 3: 2 preheat + 9 compute cycles, done in cycle 12
    start_tile(2'd0, 2, 3);
    for (int i = 0; i < 2; i++) begin
      chk("t1_pre_busy", busy_a, 1);
      chk("t1_pre_en", en_a, 0);
      tick();
    end
    for (int w = 0; w < 9; w++) begin
      chk("t1_busy", busy_a, 1);
      chk("t1_en", en_a, exp_en(w, 3, 0));
      chk("t1_stall", stall_a, 0);
      if (w == 0) chk("t1_en_w0", en_a, 16'h0001);
      if (w == 8) chk("t1_en_w8", en_a, 16'h8000);
      tick();
    end
    chk("t1_done", done_a, 1);
    chk("t1_done_busy", busy_a, 0);
    start_i = 1'b1;  // ignored in DONE
    tick();
    start_i = 1'b0;
    #1;
    chk("t1_done_pulse", done_a, 0);
    chk("t1_start_in_done_ignored", busy_a, 0);

    // Same config, row 2 ifmap empty for 3 cycles mid-COMPUTE
    do_reset();
    start_tile(2'd0, 2, 3);
    tick(); tick();
    for (int w = 0; w < 4; w++) begin
      chk("t2_en_pre", en_a, exp_en(w, 3, 0));
      tick();
    end
    ifmap_a[2] = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_en", en_a, 0);
      chk("t2_stall_mask", stall_a, 16'hFFFF);
      chk("t2_stall_busy", busy_a, 1);
      tick();
    end
    ifmap_a[2] = 1'b0;
    #1;
    for (int w = 4; w < 9; w++) begin
      chk("t2_en_post", en_a, exp_en(w, 3, 0));
      chk("t2_no_done", done_a, 0);
      tick();
    end
    chk("t2_done", done_a, 1);

    // Mode 1, tile 2, opsum column 1 full -> frozen, only diagonal stalled
    do_reset();
    opsum_a[1] = 1'b1;
    start_tile(2'd1, 0, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t3_held_en", en_a, 0);
      chk("t3_held_stall", stall_a, 16'h8421);
      tick();
    end
    opsum_a[1] = 1'b0;
    #1;
    for (int w = 0; w < 8; w++) begin
      chk("t3_dw_en", en_a, exp_en(w, 2, 1));
      chk("t3_dw_stall", stall_a, 0);
      tick();
    end
    chk("t3_done", done_a, 1);

    // 8x4 depthwise: inactive rows 5/6 empty never stall
    do_reset();
    ifmap_b[5] = 1'b1;
    ifmap_b[6] = 1'b1;
    start_tile(2'd1, 1, 1);
    chk("t4_pre_stall", stall_b, 0);
    chk("t4_pre_busy", busy_b, 1);
    tick();
    for (int w = 0; w < 7; w++) begin
      chk("t4_stall", stall_b, 0);
      if (w == 0) chk("t4_en_w0", en_b, 32'h0000_0001);
      if (w == 6) chk("t4_en_w6", en_b, 32'h0000_8000);
      tick();
    end
    chk("t4_done", done_b, 1);

    // Illegal layer type, then abort mid-COMPUTE
    do_reset();
    start_tile(2'd3, 2, 3);
    chk("t5_err", err_a, 1);
    chk("t5_err_busy", busy_a, 0);
    tick();
    chk("t5_err_pulse", err_a, 0);
    chk("t5_err_idle", busy_a, 0);
    start_tile(2'd0, 0, 3);
    tick(); tick();
    chk("t5_running", busy_a, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    #1;
    chk("t5_abort_busy", busy_a, 0);
    chk("t5_abort_en", en_a, 0);
    chk("t5_abort_stall", stall_a, 0);
    chk("t5_abort_done", done_a, 0);
    tick();
    chk("t5_abort_nodone", done_a, 0);

    // preheat 0, tile 0 -> done the cycle after start
    do_reset();
    start_tile(2'd0, 0, 0);
    chk("t6_done", done_a, 1);
    chk("t6_en", en_a, 0);
    chk("t6_busy", busy_a, 0);
    tick();
    chk("t6_done_pulse", done_a, 0);

    // rst mid-PREHEAT
    start_tile(2'd2, 5, 3);
    ifmap_a[0] = 1'b1;
    #1;
    chk("t7_pre_busy", busy_a, 1);
    chk("t7_pre_stall", stall_a, 16'h000F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t7_rst_busy", busy_a, 0);
    chk("t7_rst_stall", stall_a, 0);
    chk("t7_rst_en", en_a, 0);
    chk("t7_rst_done", done_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
